// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the multi-channel reset sequencer.
// Sizes are derived from the timing parameters so every compare fits its counter.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        StAssert,
        StRelease,
        StRun
    } state_e;

    typedef enum logic {
        PhWait,
        PhGap
    } phase_e;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable up-counter with clear and an equality match against a compare value.
// One instance is time-shared by the hold, stagger and ready-timeout counts.
module rst_seq_timer #(
    parameter int unsigned CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          inc_i,
    input  logic [CW-1:0] cmp_i,
    output logic          match_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_o = (cnt_q == cmp_i);

endmodule

// File: rtl/rst_sequencer.sv
// Multi-channel reset sequencer: holds all active-low resets, then releases them in index
// order with a stagger, optionally waiting on a per-channel READY guarded by a timeout.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned    NCH       = 4,
    parameter int unsigned    HOLD      = 15,
    parameter int unsigned    STAGGER   = 3,
    parameter logic [NCH-1:0] WAIT_MASK = 4'b0010,
    parameter int unsigned    TIMEOUT   = 255
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           sw_rst_req_i,
    input  logic [NCH-1:0] ready_i,
    output logic [NCH-1:0] out_rst_n_o,
    output logic           all_run_o,
    output logic           timeout_err_o
);

    localparam int unsigned CW = clog2(max3(HOLD, STAGGER, TIMEOUT) + 1);
    localparam int unsigned IW = clog2(NCH + 1);

    localparam logic [CW-1:0] HoldCmp = CW'(HOLD);
    localparam logic [CW-1:0] GapCmp  = CW'(STAGGER - 1);
    localparam logic [CW-1:0] WaitCmp = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LastIdx = IW'(NCH);

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          tmr_clr, tmr_inc, tmr_match;
    logic [CW-1:0] tmr_cmp;

    logic          rel_ev, done_ev, tmo_ev;
    logic          mask_next, ready_prev;

    logic [NCH-1:0] out_rst_n_q, out_rst_n_d;
    logic           all_run_q, all_run_d;
    logic           timeout_err_q, timeout_err_d;

    rst_seq_timer #(
        .CW(CW)
    ) u_timer (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (tmr_clr),
        .load_i    (1'b0),
        .load_val_i('0),
        .inc_i     (tmr_inc),
        .cmp_i     (tmr_cmp),
        .match_o   (tmr_match)
    );

    // idx_q names the next channel to release; idx_q-1 is the one whose READY may gate it.
    always_comb begin
        mask_next  = 1'b0;
        ready_prev = 1'b0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (idx_q == IW'(k)) begin
                mask_next = WAIT_MASK[k];
            end
            if (idx_q == IW'(k + 1)) begin
                ready_prev = ready_i[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StAssert;
            phase_q <= PhGap;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        tmr_cmp = HoldCmp;
        rel_ev  = 1'b0;
        done_ev = 1'b0;
        tmo_ev  = 1'b0;

        unique case (state_q)
            StAssert: begin
                if (tmr_match) begin
                    rel_ev  = 1'b1;
                    idx_d   = IW'(1);
                    state_d = StRelease;
                    phase_d = mask_next ? PhWait : PhGap;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            StRelease: begin
                if (phase_q == PhWait) begin
                    tmr_cmp = WaitCmp;
                    // A READY seen on the timeout edge itself counts as a clean handshake.
                    if (ready_prev || tmr_match) begin
                        tmo_ev  = !ready_prev;
                        phase_d = PhGap;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end else begin
                    tmr_cmp = GapCmp;
                    if (tmr_match) begin
                        tmr_clr = 1'b1;
                        if (idx_q == LastIdx) begin
                            done_ev = 1'b1;
                            state_d = StRun;
                        end else begin
                            rel_ev  = 1'b1;
                            idx_d   = idx_q + 1'b1;
                            phase_d = mask_next ? PhWait : PhGap;
                        end
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
            end
            StRun: begin
            end
            default: begin
                state_d = StAssert;
                tmr_clr = 1'b1;
            end
        endcase

        // A software request restarts the hold and keeps it at zero while held.
        if (sw_rst_req_i) begin
            state_d = StAssert;
            phase_d = PhGap;
            idx_d   = '0;
            tmr_clr = 1'b1;
            tmr_inc = 1'b0;
            rel_ev  = 1'b0;
            done_ev = 1'b0;
            tmo_ev  = 1'b0;
        end
    end

    always_comb begin
        out_rst_n_d   = out_rst_n_q;
        all_run_d     = all_run_q;
        timeout_err_d = timeout_err_q;
        if (sw_rst_req_i) begin
            out_rst_n_d = '0;
            all_run_d   = 1'b0;
        end else begin
            if (rel_ev) begin
                out_rst_n_d = (out_rst_n_q << 1) | NCH'(1);
            end
            if (done_ev) begin
                all_run_d = 1'b1;
            end
            if (tmo_ev) begin
                timeout_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_rst_n_q   <= '0;
            all_run_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            out_rst_n_q   <= out_rst_n_d;
            all_run_q     <= all_run_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign out_rst_n_o   = out_rst_n_q;
    assign all_run_o     = all_run_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench: expected release edges are derived arithmetically from the
// sequencing rules and a per-edge READY table, then compared against the DUT each edge.
module tb_rst_sequencer;

    localparam int unsigned    NCH       = 4;
    localparam int unsigned    HOLD      = 15;
    localparam int unsigned    STAGGER   = 3;
    localparam int unsigned    TIMEOUT   = 255;
    localparam logic [NCH-1:0] WAIT_MASK = 4'b0010;
    localparam int             MAXE      = 1024;

    logic           CLK = 1'b0;
    logic           RST;
    logic           sw, sw2;
    logic [NCH-1:0] ready;
    logic [NCH-1:0] out_rst_n;
    logic           all_run, terr;
    logic [0:0]     ready2;
    logic [0:0]     out2;
    logic           all_run2, terr2;

    int checks = 0;
    int errors = 0;

    logic [NCH-1:0] rdy_tab [MAXE];
    int             rel [NCH+1];
    int             tmo_e;

    always #5 CLK = ~CLK;

    rst_sequencer #(
        .NCH      (NCH),
        .HOLD     (HOLD),
        .STAGGER  (STAGGER),
        .WAIT_MASK(WAIT_MASK),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .sw_rst_req_i (sw),
        .ready_i      (ready),
        .out_rst_n_o  (out_rst_n),
        .all_run_o    (all_run),
        .timeout_err_o(terr)
    );

    rst_sequencer #(
        .NCH      (1),
        .HOLD     (0),
        .STAGGER  (3),
        .WAIT_MASK(1'b0),
        .TIMEOUT  (255)
    ) dut1 (
        .CLK          (CLK),
        .RST          (RST),
        .sw_rst_req_i (sw2),
        .ready_i      (ready2),
        .out_rst_n_o  (out2),
        .all_run_o    (all_run2),
        .timeout_err_o(terr2)
    );

    task automatic chk(input string tag, input int e, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, got, exp);
        end
    endtask

    // Release edge of every channel (rel[NCH] = ALL_RUN edge) for a sequence whose
    // first counting edge is b; tmo_e is the first timeout edge, or -1.
    function automatic void compute(input int b);
        int t;
        t     = b + int'(HOLD);
        tmo_e = -1;
        for (int k = 0; k < int'(NCH); k++) begin
            rel[k] = t;
            if (WAIT_MASK[k]) begin
                int  end_e;
                bit  got;
                end_e = t + int'(TIMEOUT);
                got   = 1'b0;
                for (int e = t + 1; e <= t + int'(TIMEOUT) && e < MAXE; e++) begin
                    if (rdy_tab[e][k]) begin
                        end_e = e;
                        got   = 1'b1;
                        break;
                    end
                end
                if (!got && tmo_e < 0) tmo_e = end_e;
                t = end_e;
            end
            t = t + int'(STAGGER);
        end
        rel[NCH] = t;
    endfunction

    task automatic run_case(input int mode);
        int             sw_at, sw_len, stop, nrst;
        bit             early, mbit, sticky, exp_terr, exp_run;
        logic [NCH-1:0] exp_out;

        sw_at  = -1;
        sw_len = 0;
        early  = 1'b0;
        for (int e = 0; e < MAXE; e++) begin
            unique case (mode)
                0, 7:    mbit = (e >= 25);
                1, 5:    mbit = 1'b0;
                2:       mbit = 1'b1;
                3:       mbit = ($urandom % 40) == 0;
                4:       mbit = ($urandom % 4) == 0;
                6:       mbit = ($urandom % 8) == 0;
                default: mbit = (e == 12 || e == 19 || e == 30 || e == 31 || e == 70);
            endcase
            rdy_tab[e] = (NCH'($urandom) & ~WAIT_MASK) | (mbit ? WAIT_MASK : '0);
        end
        if (mode == 5) begin
            sw_at  = 290;
            sw_len = 1;
        end else if (mode == 6) begin
            sw_at  = 5 + int'($urandom % 100);
            sw_len = 1 + int'($urandom % 12);
        end

        @(negedge CLK);
        RST   = 1'b1;
        sw    = 1'b0;
        ready = NCH'($urandom);
        nrst  = 1 + int'($urandom % 4);
        for (int i = 0; i < nrst; i++) begin
            @(posedge CLK);
            #1;
            chk("rst_out_rst_n", 0, 32'(out_rst_n), 32'(0));
            chk("rst_all_run", 0, 32'(all_run), 32'(0));
            chk("rst_timeout_err", 0, 32'(terr), 32'(0));
        end
        @(negedge CLK);
        RST      = 1'b0;
        sticky   = 1'b0;
        exp_terr = 1'b0;
        compute(1);
        stop = rel[NCH] + 12;
        if (mode == 7) begin
            early = 1'b1;
            stop  = 20 + int'($urandom % 40);
        end

        for (int e = 1; e <= stop && e < MAXE; e++) begin
            ready = rdy_tab[e];
            sw    = (sw_at > 0 && e >= sw_at && e < sw_at + sw_len);
            @(posedge CLK);
            #1;
            if (sw) begin
                sticky = exp_terr;
                compute(e + 1);
                if (!early) stop = rel[NCH] + 12;
            end
            for (int k = 0; k < int'(NCH); k++) exp_out[k] = (e >= rel[k]);
            exp_run  = (e >= rel[NCH]);
            exp_terr = sticky || (tmo_e > 0 && e >= tmo_e);
            chk("out_rst_n", e, 32'(out_rst_n), 32'(exp_out));
            chk("all_run", e, 32'(all_run), 32'(exp_run));
            chk("timeout_err", e, 32'(terr), 32'(exp_terr));
            @(negedge CLK);
        end
        sw = 1'b0;
    endtask

    initial begin
        int  b;
        bit  in_sw;
        RST    = 1'b1;
        sw     = 1'b0;
        sw2    = 1'b0;
        ready  = '0;
        ready2 = '0;

        run_case(0);
        run_case(1);
        run_case(5);
        run_case(7);
        run_case(6);
        run_case(6);
        run_case(6);
        run_case(8);
        run_case(3);
        run_case(4);
        run_case(2);

        // Single-channel, zero-hold instance with a held software request.
        @(negedge CLK);
        RST = 1'b1;
        sw2 = 1'b0;
        @(posedge CLK);
        #1;
        chk("n1_rst_out", 0, 32'(out2), 32'(0));
        chk("n1_rst_run", 0, 32'(all_run2), 32'(0));
        @(negedge CLK);
        RST = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            ready2 = 1'($urandom);
            in_sw  = (e >= 5 && e <= 14);
            sw2    = in_sw;
            @(posedge CLK);
            #1;
            b = (e < 5) ? 1 : 15;
            chk("n1_out_rst_n", e, 32'(out2), 32'(!in_sw && e >= b));
            chk("n1_all_run", e, 32'(all_run2), 32'(!in_sw && e >= b + 3));
            chk("n1_timeout_err", e, 32'(terr2), 32'(0));
            @(negedge CLK);
        end
        sw2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
